// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM read-side sequencer and its display consumers.
package ram_reader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PACE    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_reader_pace_counter.sv
// Loadable down-counter with a zero flag; used for both pacing and read latency.
module pace_counter #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_d, count_q;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ram_reader.sv
// Sequential RAM sweep: read every address once, report each word and a running checksum.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for start
//   ISSUE   | address stable, latency counter loaded
//   WAIT    | counting down the RAM read latency
//   CAPTURE | latch ram_q, update checksum, pulse out_valid next cycle
//   PACE    | auto: wait TICK_DIV clocks; manual: wait for step
//   DONE    | last address captured, outputs held
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              auto_mode,
  input  logic              step,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              done
);

  localparam int PACE_W = cnt_width(TICK_DIV);
  localparam int LAT_W  = cnt_width(RD_LAT);
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(TICK_DIV - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] out_addr_d, out_addr_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic [DATA_W-1:0] checksum_d, checksum_q;
  logic              out_valid_d, out_valid_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              lat_load, lat_en, lat_zero;
  logic              pace_load, pace_en, pace_zero;

  pace_counter #(.W(LAT_W)) u_lat_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .en       (lat_en),
    .zero     (lat_zero)
  );

  pace_counter #(.W(PACE_W)) u_pace_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .load     (pace_load),
    .load_val (PACE_LOAD),
    .en       (pace_en),
    .zero     (pace_zero)
  );

  // Next-state and datapath decisions; stop always returns to IDLE without capturing.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    out_valid_d = 1'b0;
    lat_load    = 1'b0;
    lat_en      = 1'b0;
    pace_load   = 1'b0;
    pace_en     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          addr_d     = '0;
          checksum_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          lat_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (lat_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          lat_en = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          out_addr_d  = addr_q;
          out_data_d  = ram_q;
          checksum_d  = checksum_q + ram_q;
          out_valid_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            pace_load = 1'b1;
            state_d   = ST_PACE;
          end
        end
      end
      ST_PACE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (auto_mode) begin
          if (pace_zero) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_ISSUE;
          end else begin
            pace_en = 1'b1;
          end
        end else if (step) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
             (state_d == ST_CAPTURE) || (state_d == ST_PACE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_wren    = 1'b0;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign checksum    = checksum_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: RAM models with 1- and 2-cycle latency, queue-based scoreboard.
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TD = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, start2 = 1'b0, stop = 1'b0, auto_mode = 1'b1, step = 1'b0;
  logic [DW-1:0] ram_q = '0, ram_q2 = '0;
  logic [AW-1:0] ram_address, out_addr, ram_address2, out_addr2, ram_a2 = '0;
  logic [DW-1:0] out_data, checksum, out_data2, checksum2;
  logic ram_wren, out_valid, busy, done, ram_wren2, out_valid2, busy2, done2;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] mem2 [32];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int t; } cap_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
  cap_t cap_q[$];
  cap_t cap2_q[$];
  exp_t exp_q[$];
  exp_t exp2_q[$];

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .TICK_DIV(TD)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .auto_mode(auto_mode),
    .step(step), .ram_q(ram_q), .ram_address(ram_address), .ram_wren(ram_wren),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
    .checksum(checksum), .busy(busy), .done(done));

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .TICK_DIV(TD)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .stop(stop), .auto_mode(auto_mode),
    .step(step), .ram_q(ram_q2), .ram_address(ram_address2), .ram_wren(ram_wren2),
    .out_addr(out_addr2), .out_data(out_data2), .out_valid(out_valid2),
    .checksum(checksum2), .busy(busy2), .done(done2));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // 1-cycle RAM for dut, 2-cycle pipelined RAM for dut2.
  always @(posedge clock) ram_q <= mem[ram_address];
  always @(posedge clock) begin
    ram_a2 <= ram_address2;
    ram_q2 <= mem2[ram_a2];
  end

  // Record every capture, sampled away from the active edge.
  always @(negedge clock) begin
    if (out_valid)  cap_q.push_back(cap_t'{out_addr, out_data, cyc});
    if (out_valid2) cap2_q.push_back(cap_t'{out_addr2, out_data2, cyc});
  end

  // Callers sit just after an edge; pulses last exactly one sampling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clock); #1;
    step = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_done(input bit second, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if ((second ? done2 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    wait_cycles(2);
  endtask

  task automatic wait_state(input state_e s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (dut.state_q == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_mem_index();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
  endtask

  task automatic push_full_sweep();
    exp_q.delete();
    cap_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_t'{5'(i), mem[i]});
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({ram_address, out_addr, out_data, checksum, out_valid, busy, done, ram_wren} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0h oaddr=%0h odata=%0h csum=%0h v=%b busy=%b done=%b wren=%b, all required 0",
               ram_address, out_addr, out_data, checksum, out_valid, busy, done, ram_wren);
    end
    n_checks++;
    if (ram_wren2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wren2: got %b required 0", ram_wren2);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 1'b0;
    auto_mode = 1'b1;
    fill_mem_index();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (ram_address == 5'd7) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_mid_reach7: address 7 not reached, got %0d", ram_address);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({ram_address, out_addr, out_data, checksum, out_valid, busy, done} !== '0 ||
        dut.state_q != ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: got addr=%0h oaddr=%0h odata=%0h csum=%0h v=%b busy=%b done=%b, all required 0 and IDLE",
               ram_address, out_addr, out_data, checksum, out_valid, busy, done);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    wait_cycles(2);
    cap_q.delete();
    cap2_q.delete();
  endtask

  task automatic test_auto_sweep();
    bit ok;
    cap_t c;
    exp_t e;
    int prev_t;
    auto_mode = 1'b1;
    fill_mem_index();
    push_full_sweep();
    pulse_start();
    wait_done(1'b0, 1500, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL auto_timeout: done not seen, got done=%b required 1", done);
    end
    n_checks++;
    if (cap_q.size() != 32) begin
      n_fail++;
      $display("FAIL auto_count: got %0d captures required 32", cap_q.size());
    end
    prev_t = -1;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (c.a !== e.a || c.d !== e.d || c.d !== 8'(c.a)) begin
        n_fail++;
        $display("FAIL auto_word: got addr=%0h data=%0h required addr=%0h data=%0h", c.a, c.d, e.a, e.d);
      end
      if (prev_t >= 0) begin
        n_checks++;
        if (c.t - prev_t != 7) begin
          n_fail++;
          $display("FAIL auto_interval: got %0d clocks required 7 at addr %0h", c.t - prev_t, c.a);
        end
      end
      prev_t = c.t;
    end
    n_checks++;
    if (checksum !== 8'hF0 || done !== 1'b1 || busy !== 1'b0 || ram_address !== 5'd31) begin
      n_fail++;
      $display("FAIL auto_final: got csum=%0h done=%b busy=%b addr=%0h required F0 1 0 1f",
               checksum, done, busy, ram_address);
    end
  endtask

  task automatic test_latency();
    bit ok;
    cap_t c;
    exp_t e;
    logic [DW-1:0] sum;
    sum = '0;
    auto_mode = 1'b1;
    exp2_q.delete();
    cap2_q.delete();
    for (int i = 0; i < 32; i++) begin
      mem2[i] = 8'hA5 ^ 8'(i);
      exp2_q.push_back(exp_t'{5'(i), 8'hA5 ^ 8'(i)});
      sum = sum + (8'hA5 ^ 8'(i));
    end
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    wait_done(1'b1, 1500, ok);
    n_checks++;
    if (!ok || cap2_q.size() != 32) begin
      n_fail++;
      $display("FAIL lat_count: got done=%b captures=%0d required 1 and 32", done2, cap2_q.size());
    end
    while (cap2_q.size() > 0 && exp2_q.size() > 0) begin
      c = cap2_q.pop_front();
      e = exp2_q.pop_front();
      n_checks++;
      if (c.a !== e.a || c.d !== e.d) begin
        n_fail++;
        $display("FAIL lat_word: got addr=%0h data=%0h required addr=%0h data=%0h", c.a, c.d, e.a, e.d);
      end
    end
    n_checks++;
    if (checksum2 !== sum) begin
      n_fail++;
      $display("FAIL lat_checksum: got %0h required %0h", checksum2, sum);
    end
  endtask

  task automatic test_manual();
    bit ok;
    cap_t c;
    exp_t e;
    auto_mode = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    exp_q.delete();
    cap_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{5'(i), 8'hFF});
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_state(ST_PACE, 100, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL manual_pace_%0d: PACE not reached, got state %0d", k, dut.state_q);
      end
      wait_cycles(k + 3);
      pulse_step();
    end
    wait_state(ST_WAIT, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL manual_wait: WAIT not reached, got state %0d", dut.state_q);
    end
    pulse_step();
    wait_cycles(40);
    n_checks++;
    if (cap_q.size() != 4) begin
      n_fail++;
      $display("FAIL manual_count: got %0d captures required 4", cap_q.size());
    end
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (c.a !== e.a || c.d !== e.d) begin
        n_fail++;
        $display("FAIL manual_word: got addr=%0h data=%0h required addr=%0h data=%0h", c.a, c.d, e.a, e.d);
      end
    end
    n_checks++;
    if (checksum !== 8'hFC || out_addr !== 5'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_final: got csum=%0h oaddr=%0h busy=%b required fc 3 1", checksum, out_addr, busy);
    end
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    wait_cycles(1);
    auto_mode = 1'b1;
    cap_q.delete();
  endtask

  task automatic test_stop_restart();
    bit ok;
    cap_t c;
    exp_t e;
    ok = 1'b0;
    fill_mem_index();
    push_full_sweep();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1 && out_addr == 5'd10) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stop_reach10: capture of address 10 not seen, got oaddr=%0h", out_addr);
    end
    stop = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (dut.state_q != ST_IDLE || busy !== 1'b0 || out_addr !== 5'd10 || checksum !== 8'h37) begin
      n_fail++;
      $display("FAIL stop_hold: got state=%0d busy=%b oaddr=%0h csum=%0h required IDLE 0 a 37",
               dut.state_q, busy, out_addr, checksum);
    end
    pulse_start();
    wait_cycles(20);
    n_checks++;
    if (dut.state_q != ST_IDLE || busy !== 1'b0 || cap_q.size() != 11) begin
      n_fail++;
      $display("FAIL stop_start_blocked: got state=%0d busy=%b captures=%0d required IDLE 0 11",
               dut.state_q, busy, cap_q.size());
    end
    stop = 1'b0;
    wait_cycles(1);
    push_full_sweep();
    pulse_start();
    n_checks++;
    if (checksum !== 8'h00 || busy !== 1'b1 || ram_address !== 5'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got csum=%0h busy=%b addr=%0h required 0 1 0", checksum, busy, ram_address);
    end
    wait_done(1'b0, 1500, ok);
    n_checks++;
    if (!ok || cap_q.size() != 32 || checksum !== 8'hF0) begin
      n_fail++;
      $display("FAIL restart_sweep: got done=%b captures=%0d csum=%0h required 1 32 f0",
               done, cap_q.size(), checksum);
    end
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (c.a !== e.a || c.d !== e.d) begin
        n_fail++;
        $display("FAIL restart_word: got addr=%0h data=%0h required addr=%0h data=%0h", c.a, c.d, e.a, e.d);
      end
    end
  endtask

  task automatic test_done_restart();
    bit ok;
    cap_t c;
    exp_t e;
    int prev_t;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pre: got done=%b required 1", done);
    end
    push_full_sweep();
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_drop: got done=%b busy=%b required 0 1", done, busy);
    end
    wait_cycles(40);
    pulse_start();
    wait_cycles(53);
    pulse_start();
    wait_done(1'b0, 1500, ok);
    n_checks++;
    if (!ok || cap_q.size() != 32 || checksum !== 8'hF0) begin
      n_fail++;
      $display("FAIL done_resweep: got done=%b captures=%0d csum=%0h required 1 32 f0",
               done, cap_q.size(), checksum);
    end
    prev_t = -1;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (c.a !== e.a || c.d !== e.d) begin
        n_fail++;
        $display("FAIL done_word: got addr=%0h data=%0h required addr=%0h data=%0h", c.a, c.d, e.a, e.d);
      end
      if (prev_t >= 0) begin
        n_checks++;
        if (c.t - prev_t != 7) begin
          n_fail++;
          $display("FAIL done_interval: got %0d clocks required 7 at addr %0h", c.t - prev_t, c.a);
        end
      end
      prev_t = c.t;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      mem2[i] = '0;
    end
    test_reset();
    test_reset_mid();
    test_auto_sweep();
    test_latency();
    test_manual();
    test_stop_restart();
    test_done_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
